hart_rate_meter: RTL and testbench
==================================

HART_RATE_METER -- requirements
Module: hart_rate_meter

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per measurement tick (1 kHz at 50 MHz).
REQ-002 Parameter CNT_W, default 12: interval counter width in ticks.
REQ-003 Parameter AVG_LOG2, default 2: log2 of averaging window depth (4 intervals).
REQ-004 Parameter LEVEL_W, default 8: width of hartvol.
REQ-005 Parameter MIN_IVL, default 250: refractory interval in ticks; shorter edges are rejected.
REQ-006 Parameter MAX_IVL, default 2000: timeout interval in ticks; must be < 2^CNT_W.
REQ-007 Parameter STRESS_IVL, default 500: average interval below which stress asserts.
REQ-008 Parameter LVL_SHIFT, default 3: right shift applied in the level mapping.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 hartin  in  1  raw heartbeat pulse, asynchronous to clk.
REQ-012 hartvol  out  LEVEL_W  heart-rate level, 0 unless locked.
REQ-013 beat  out  1  one-cycle pulse per accepted beat.
REQ-014 locked  out  1  high in state TRACK.
REQ-015 stress  out  1  high when locked and average interval < STRESS_IVL.
REQ-016 lost  out  1  high in state LOST.

Function
REQ-017 hartin SHALL pass a 2-FF synchronizer and then a rising-edge detector; beat SHALL assert exactly 3 clk cycles after the hartin rising edge is sampled.
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap.
REQ-019 Interval counter SHALL increment on tick and saturate at MAX_IVL.
REQ-020 In ACQUIRE/TRACK, an edge with interval >= MIN_IVL is accepted: beat pulses, interval is captured, and the counter clears to 0; an edge with interval < MIN_IVL is ignored (no beat, counter unchanged).
REQ-021 Edge coincident with tick: edge wins; captured value is the pre-increment count, counter becomes 0.
REQ-022 FSM states IDLE, ACQUIRE, TRACK, LOST; reset -> IDLE.
REQ-023 IDLE/LOST: first edge is always accepted (beat pulses, counter clears, window cleared, no interval stored) -> ACQUIRE.
REQ-024 ACQUIRE: each accepted interval is pushed into the window; when 2^AVG_LOG2 intervals are stored -> TRACK.
REQ-025 TRACK: accepted intervals replace the oldest window entry.
REQ-026 ACQUIRE/TRACK: counter reaching MAX_IVL -> LOST in the same cycle the saturation value is reached; window contents discarded.
REQ-027 Window: circular buffer of 2^AVG_LOG2 entries x CNT_W; running sum width CNT_W+AVG_LOG2, updated as sum + new - oldest; avg = sum >> AVG_LOG2.
REQ-028 hartvol SHALL be min(2^LEVEL_W-1, (MAX_IVL - avg) >> LVL_SHIFT) in TRACK, updated 1 cycle after the sum update, and 0 in every other state.
REQ-029 stress and hartvol SHALL change in the same cycle.

Reset
REQ-030 Reset SHALL clear synchronizer, prescaler, counter, window, sum, and set state to IDLE.
REQ-031 Output values during and after reset: hartvol=0, beat=0, locked=0, stress=0, lost=0.
REQ-032 Reset asserted mid-TRACK SHALL take effect on the next clk edge with no residual beat pulse.

Structure
REQ-033 Package hart_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Sub-module pulse_sync_edge SHALL implement the synchronizer and edge detector; all other logic SHALL reside in hart_rate_meter.

Verification (bench uses TICK_DIV=2, other defaults)
REQ-035 Pulses every 1000 ticks -> locked after the 5th beat, avg=1000, hartvol=125, stress=0.
REQ-036 Pulses every 400 ticks -> avg=400, hartvol=200, stress=1.
REQ-037 Locked at 1000, extra pulse 100 ticks after a beat -> no beat, hartvol stays 125.
REQ-038 Locked, then no pulse for 2000 ticks -> lost=1, locked=0, hartvol=0; next pulse -> ACQUIRE, lost=0.
REQ-039 Reset pulsed for 1 cycle while in TRACK -> all outputs 0 on the next cycle, state IDLE.
REQ-040 hartin edge aligned with tick -> captured interval equals the pre-increment count; beat 3 cycles after the edge.

Source files
------------

// File: rtl/hart_pkg.sv
// hart_pkg -- shared definitions for the heart-rate meter.
//   hart_state_e : tracking FSM state encoding
//   *_DEF        : default values for the hart_rate_meter parameters
package hart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOST    = 2'd3
  } hart_state_e;

  localparam int unsigned TICK_DIV_DEF   = 50000;
  localparam int unsigned CNT_W_DEF      = 12;
  localparam int unsigned AVG_LOG2_DEF   = 2;
  localparam int unsigned LEVEL_W_DEF    = 8;
  localparam int unsigned MIN_IVL_DEF    = 250;
  localparam int unsigned MAX_IVL_DEF    = 2000;
  localparam int unsigned STRESS_IVL_DEF = 500;
  localparam int unsigned LVL_SHIFT_DEF  = 3;

endpackage

// File: rtl/hart_rate_meter_if.sv
// hart_rate_meter_if -- heartbeat input and rate outputs of the meter.
//   hartin  : raw heartbeat pulse (asynchronous to clk)
//   hartvol : heart-rate level, 0 unless locked
//   beat    : one-cycle pulse per accepted beat
//   locked  : tracking a stable rhythm
//   stress  : locked and average interval below the stress threshold
//   lost    : rhythm timed out
// master = pulse source / observer, slave = the meter.
interface hart_rate_meter_if
  import hart_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF
);

  logic               hartin;
  logic [LEVEL_W-1:0] hartvol;
  logic               beat;
  logic               locked;
  logic               stress;
  logic               lost;

  modport master (
    output hartin,
    input  hartvol, beat, locked, stress, lost
  );

  modport slave (
    input  hartin,
    output hartvol, beat, locked, stress, lost
  );

endinterface

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge -- two-flop synchronizer followed by a registered
// rising-edge detector.
//   clk, reset : clock and synchronous active-high reset
//   async_i    : asynchronous input level
//   edge_o     : one-cycle pulse, high 3 edges after async_i is first sampled high
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      edge_q <= sync_q[1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/hart_rate_meter.sv
// hart_rate_meter -- measures the interval between heartbeat pulses in
// ticks, averages the last 2^AVG_LOG2 intervals and maps the average to a
// rate level.
//   clk, reset : clock and synchronous active-high reset
//   bus        : hart_rate_meter_if.slave (hartin in; hartvol, beat,
//                locked, stress, lost out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset, waiting for the first pulse
// ST_ACQUIRE | filling the averaging window
// ST_TRACK   | window full, level and stress valid
// ST_LOST    | no accepted pulse for MAX_IVL ticks, window discarded
module hart_rate_meter
  import hart_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
  parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
  parameter int unsigned MIN_IVL    = MIN_IVL_DEF,
  parameter int unsigned MAX_IVL    = MAX_IVL_DEF,
  parameter int unsigned STRESS_IVL = STRESS_IVL_DEF,
  parameter int unsigned LVL_SHIFT  = LVL_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hart_rate_meter_if.slave bus
);

  localparam int DEPTH  = 2 ** AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_IVL);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_IVL);
  localparam logic [CNT_W-1:0] STRESS_C  = CNT_W'(STRESS_IVL);
  localparam logic [31:0]      LVL_MAX   = (32'd1 << LEVEL_W) - 32'd1;

  logic edge_pulse;

  pulse_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.hartin),
    .edge_o  (edge_pulse)
  );

  hart_state_e         state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                beat_q, beat_d;
  logic [LEVEL_W-1:0]  hartvol_q, hartvol_d;
  logic                stress_q, stress_d;
  logic [CNT_W-1:0]    win_q [DEPTH];

  logic             tick;
  logic             accept;
  logic             win_clr;
  logic             win_we;
  logic             track_stable;
  logic [CNT_W-1:0] avg;
  logic [31:0]      lvl_raw;

  assign tick = (presc_q == TICK_LAST);
  assign avg  = CNT_W'(sum_q >> AVG_LOG2);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    beat_d  = 1'b0;
    accept  = 1'b0;
    win_clr = 1'b0;
    win_we  = 1'b0;

    if (tick && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_LOST: begin
        if (edge_pulse) begin
          accept  = 1'b1;
          win_clr = 1'b1;
          ptr_d   = '0;
          fill_d  = '0;
          sum_d   = '0;
          state_d = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE, ST_TRACK: begin
        if (edge_pulse && (cnt_q >= MIN_C)) begin
          // Captured value is cnt_q, so a coincident tick is discarded.
          // Unfilled slots hold 0, so one update form covers both states.
          accept = 1'b1;
          win_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          sum_d  = sum_q + SUM_W'(cnt_q) - SUM_W'(win_q[ptr_q]);
          if (state_q == ST_ACQUIRE) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FILL_W'(DEPTH - 1)) begin
              state_d = ST_TRACK;
            end
          end
        end else if (cnt_d == MAX_C) begin
          win_clr = 1'b1;
          ptr_d   = '0;
          fill_d  = '0;
          sum_d   = '0;
          state_d = ST_LOST;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      cnt_d  = '0;
      beat_d = 1'b1;
    end
  end

  // Level and stress follow the registered sum one cycle later; both are
  // forced to 0 on the edge that leaves TRACK and during the entry cycle,
  // when the sum has just been loaded.
  always_comb begin
    track_stable = (state_q == ST_TRACK) && (state_d == ST_TRACK);
    lvl_raw      = '0;
    if (avg < MAX_C) begin
      lvl_raw = 32'(MAX_C - avg) >> LVL_SHIFT;
    end
    hartvol_d = '0;
    stress_d  = 1'b0;
    if (track_stable) begin
      hartvol_d = (lvl_raw > LVL_MAX) ? LEVEL_W'(LVL_MAX) : LEVEL_W'(lvl_raw);
      stress_d  = (avg < STRESS_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      beat_q    <= 1'b0;
      hartvol_q <= '0;
      stress_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      beat_q    <= beat_d;
      hartvol_q <= hartvol_d;
      stress_q  <= stress_d;
      if (win_clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          win_q[i] <= '0;
        end
      end else if (win_we) begin
        win_q[ptr_q] <= cnt_q;
      end
    end
  end

  assign bus.hartvol = hartvol_q;
  assign bus.beat    = beat_q;
  assign bus.stress  = stress_q;
  assign bus.locked  = (state_q == ST_TRACK);
  assign bus.lost    = (state_q == ST_LOST);

endmodule

// File: tb/tb_hart_rate_meter.sv
module tb_hart_rate_meter;

  localparam int TD     = 2;
  localparam int MINI   = 250;
  localparam int MAXI   = 2000;
  localparam int STRI   = 500;
  localparam int WIN    = 4;
  localparam int LSH    = 3;
  localparam int LVLMAX = 255;

  logic clk = 1'b0;
  logic reset;

  hart_rate_meter_if #(.LEVEL_W(8)) bus ();

  hart_rate_meter #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_err;
  int n_chk;
  int cyc;

  // Reference model: edge indices counted from the first edge after reset.
  // Ticks land on edges that are multiples of TD.
  int m_last;
  bit m_active;
  bit m_lost;
  int m_q[$];

  function automatic int ticks_in(input int a, input int e);
    return (e / TD) - (a / TD);
  endfunction

  function automatic int m_sum();
    int s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  function automatic bit m_locked();
    return m_active && (m_q.size() == WIN);
  endfunction

  function automatic int m_avg();
    return m_sum() / WIN;
  endfunction

  function automatic int m_level();
    int lvl;
    if (!m_locked()) return 0;
    lvl = (m_avg() < MAXI) ? (MAXI - m_avg()) / (1 << LSH) : 0;
    return (lvl > LVLMAX) ? LVLMAX : lvl;
  endfunction

  function automatic bit m_stress();
    return m_locked() && (m_avg() < STRI);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_lost   = 1'b0;
    m_last   = 0;
    m_q.delete();
  endtask

  task automatic model_refresh(input int e);
    if (m_active && ticks_in(m_last, e) >= MAXI) begin
      m_active = 1'b0;
      m_lost   = 1'b1;
      m_q.delete();
    end
  endtask

  task automatic model_edge(input int b, output bit acc);
    int iv;
    model_refresh(b - 1);
    acc = 1'b0;
    if (!m_active) begin
      acc      = 1'b1;
      m_active = 1'b1;
      m_lost   = 1'b0;
      m_q.delete();
      m_last   = b;
    end else begin
      iv = ticks_in(m_last, b - 1);
      if (iv >= MINI) begin
        acc = 1'b1;
        m_q.push_back(iv);
        if (m_q.size() > WIN) void'(m_q.pop_front());
        m_last = b;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_locked"},  32'(bus.locked),  32'(m_locked()));
    check({tag, "_lost"},    32'(bus.lost),    32'(m_lost));
    check({tag, "_stress"},  32'(bus.stress),  32'(m_stress()));
    check({tag, "_hartvol"}, 32'(bus.hartvol), 32'(m_level()));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Raises hartin now; the meter decides on the 4th edge from here.
  task automatic send_pulse(input string tag);
    int b;
    bit acc;
    b = cyc + 4;
    model_edge(b, acc);
    bus.hartin = 1'b1;
    step(); step(); step();
    check({tag, "_beat_early"}, 32'(bus.beat), 32'd0);
    step();
    check({tag, "_beat"}, 32'(bus.beat), 32'(acc));
    bus.hartin = 1'b0;
    step();
    check({tag, "_beat_once"}, 32'(bus.beat), 32'd0);
    check_state(tag);
  endtask

  // Pulse timed so the captured interval is iv ticks after the last accepted
  // beat; aligned places the decision edge on a tick edge.
  task automatic pulse_iv(input string tag, input int iv, input bit aligned);
    int fa;
    int b;
    fa = m_last / TD;
    b  = aligned ? TD * (iv + fa + 1) : TD * (iv + fa) + 1;
    wait_until(b - 4);
    send_pulse(tag);
  endtask

  initial begin
    int iv;
    int e;
    n_err      = 0;
    n_chk      = 0;
    cyc        = 0;
    bus.hartin = 1'b0;
    reset      = 1'b1;
    model_reset();

    repeat (3) step();
    check("rst_hartvol", 32'(bus.hartvol), 32'd0);
    check("rst_beat",    32'(bus.beat),    32'd0);
    check("rst_locked",  32'(bus.locked),  32'd0);
    check("rst_stress",  32'(bus.stress),  32'd0);
    check("rst_lost",    32'(bus.lost),    32'd0);
    reset = 1'b0;
    cyc   = 0;
    repeat (5) step();
    check("idle_beat", 32'(bus.beat), 32'd0);
    check_state("idle");

    // Acquire and lock at 1000 ticks
    wait_until(20);
    send_pulse("first");
    for (int i = 0; i < 4; i++) pulse_iv("acq1000", 1000, i[0]);
    check("lock1000_locked",  32'(bus.locked),  32'd1);
    check("lock1000_hartvol", 32'(bus.hartvol), 32'd125);
    check("lock1000_stress",  32'(bus.stress),  32'd0);

    // Early extra pulse is rejected
    pulse_iv("early", 100, 1'b0);
    check("early_hartvol", 32'(bus.hartvol), 32'd125);
    pulse_iv("after_early", 1000, 1'b1);

    // Window sums of 32m+3 / 32m+4 sit on a level step, so an off-by-one
    // captured interval changes hartvol.
    for (int k = 0; k < 3; k++) begin
      iv = 1000;
      while (((m_sum() - m_q[0] + iv) % (WIN << LSH)) != ((k == 1) ? 4 : 3)) iv++;
      pulse_iv("tick_edge", iv, k != 2);
    end

    // Fast rhythm -> stress
    for (int i = 0; i < 5; i++) pulse_iv("fast400", 400, i[0]);
    check("fast400_hartvol", 32'(bus.hartvol), 32'd200);
    check("fast400_stress",  32'(bus.stress),  32'd1);

    // Randomized rhythm with occasional early pulses
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_iv("rand_early", $urandom_range(20, 200), 1'($urandom_range(0, 1)));
      pulse_iv("rand", $urandom_range(MINI, MAXI - 1), 1'($urandom_range(0, 1)));
    end

    // Interval limits
    pulse_iv("min_ivl", MINI, 1'b1);
    pulse_iv("below_min", MINI - 1, 1'b0);
    pulse_iv("max_minus1", MAXI - 1, 1'b1);
    check("max_minus1_lost", 32'(bus.lost), 32'd0);

    // Timeout to LOST on the exact saturating tick
    e = TD * (MAXI + m_last / TD);
    wait_until(e - 1);
    model_refresh(cyc);
    check("pre_timeout_lost",   32'(bus.lost),   32'd0);
    check("pre_timeout_locked", 32'(bus.locked), 32'(m_locked()));
    step();
    model_refresh(cyc);
    check("timeout_lost",    32'(bus.lost),    32'd1);
    check("timeout_locked",  32'(bus.locked),  32'd0);
    check("timeout_hartvol", 32'(bus.hartvol), 32'd0);
    check_state("timeout");

    wait_until(cyc + 50);
    send_pulse("reacq");
    check("reacq_lost",   32'(bus.lost),   32'd0);
    check("reacq_locked", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 4; i++) pulse_iv("lock600", 600, i[0]);
    check("lock600_hartvol", 32'(bus.hartvol), 32'd175);

    // Reset while locked with a pulse in flight
    wait_until(cyc + 20);
    check("pre_reset_locked", 32'(bus.locked), 32'd1);
    bus.hartin = 1'b1;
    step(); step();
    reset      = 1'b1;
    bus.hartin = 1'b0;
    step();
    check("rst_track_hartvol", 32'(bus.hartvol), 32'd0);
    check("rst_track_beat",    32'(bus.beat),    32'd0);
    check("rst_track_locked",  32'(bus.locked),  32'd0);
    check("rst_track_stress",  32'(bus.stress),  32'd0);
    check("rst_track_lost",    32'(bus.lost),    32'd0);
    reset = 1'b0;
    cyc   = 0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_no_beat", 32'(bus.beat), 32'd0);
    end
    check_state("after_rst");
    wait_until(30);
    send_pulse("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
